// File: rtl/core_dispatch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_dispatch_ctrl_pkg
//  Description : Shared definitions for the core dispatch controller and its
//                neighbours (distributor, scheduler): default sizes and the
//                dispatch FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_dispatch_ctrl_pkg;

    localparam int N_CORES = 16;
    localparam int MSG_W   = 16;
    localparam int LEN_W   = 8;

    localparam int C_ST_W = 3;

    localparam logic [C_ST_W-1:0] C_ST_IDLE       = 3'd0;
    localparam logic [C_ST_W-1:0] C_ST_WAIT_RTR   = 3'd1;
    localparam logic [C_ST_W-1:0] C_ST_ISSUE      = 3'd2;
    localparam logic [C_ST_W-1:0] C_ST_HOLD       = 3'd3;
    localparam logic [C_ST_W-1:0] C_ST_WAIT_READY = 3'd4;
    localparam logic [C_ST_W-1:0] C_ST_FINISH     = 3'd5;

    // States in which the watchdog is counting.
    function automatic logic is_wait_state(input logic [C_ST_W-1:0] st);
        return (st == C_ST_WAIT_RTR) || (st == C_ST_WAIT_READY);
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_dispatch_ctrl_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_wdog
//  Description : Wait-state watchdog. Counts cycles while en is high, is
//                cleared by clr (clr wins over en), and flags expired in the
//                cycle the count reaches TIMEOUT_CYC-1 while still enabled.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                clr          - restart the count from zero
//                en           - count this cycle
//                expired      - limit reached in an enabled cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module dispatch_wdog
    import core_dispatch_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int C_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(TIMEOUT_CYC - 1);

    logic [C_CNT_W-1:0] cnt_q;
    logic [C_CNT_W-1:0] cnt_d;

    // Saturate at the limit so a stalled enable can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != C_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/core_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : core_dispatch_ctrl
//  Description : Issues a program of ins_len instruction words to a set of
//                cores. Each word waits until every targeted core is ready
//                to receive, is popped from the source, strobed to the
//                distributor, then followed by two dead cycles that mask the
//                distributor's status lag. After the last word the block
//                waits for all targeted cores to report done. Any single
//                wait longer than TIMEOUT_CYC cycles aborts with err.
//  Ports       : clk, rst               - clock, synchronous active-high reset
//                start, core_mask,
//                ins_len                - launch request and its arguments
//                ins_data, ins_valid,
//                ins_rd                 - instruction source (ins_rd pops)
//                mess_from_ts, if_val   - registered word/strobe to distributor
//                active_core            - latched target mask
//                rtr_bus, ready_bus     - per-core ready-to-receive / done
//                busy, done, err        - status (done pulses, err sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
module core_dispatch_ctrl
    import core_dispatch_ctrl_pkg::*;
#(
    parameter int N_CORES     = core_dispatch_ctrl_pkg::N_CORES,
    parameter int MSG_W       = core_dispatch_ctrl_pkg::MSG_W,
    parameter int LEN_W       = core_dispatch_ctrl_pkg::LEN_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_CORES-1:0] core_mask,
    input  logic [LEN_W-1:0]   ins_len,
    input  logic [MSG_W-1:0]   ins_data,
    input  logic               ins_valid,
    output logic               ins_rd,
    output logic [MSG_W-1:0]   mess_from_ts,
    output logic               if_val,
    output logic [N_CORES-1:0] active_core,
    input  logic [N_CORES-1:0] rtr_bus,
    input  logic [N_CORES-1:0] ready_bus,
    output logic               busy,
    output logic               done,
    output logic               err
);

    logic [C_ST_W-1:0]  state_q,       state_d;
    logic [N_CORES-1:0] active_core_q, active_core_d;
    logic [LEN_W-1:0]   word_cnt_q,    word_cnt_d;
    logic [MSG_W-1:0]   mess_q,        mess_d;
    logic               if_val_q,      if_val_d;
    logic               err_q,         err_d;
    logic               hold_cnt_q,    hold_cnt_d;

    logic w_all_rtr;
    logic w_all_ready;
    logic w_pop;
    logic w_expired;
    logic w_wdog_clr;
    logic w_wdog_en;

    assign w_all_rtr   = ((rtr_bus   & active_core_q) == active_core_q);
    assign w_all_ready = ((ready_bus & active_core_q) == active_core_q);
    assign w_pop       = (state_q == C_ST_WAIT_RTR) && w_all_rtr && ins_valid;

    // Restart the watchdog on every entry into a wait state, including the
    // HOLD -> WAIT_RTR re-entry between words.
    assign w_wdog_en  = is_wait_state(state_q);
    assign w_wdog_clr = is_wait_state(state_d) && (state_d != state_q);

    dispatch_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_wdog_clr),
        .en      (w_wdog_en),
        .expired (w_expired)
    );

    always_comb begin
        state_d       = state_q;
        active_core_d = active_core_q;
        word_cnt_d    = word_cnt_q;
        mess_d        = mess_q;
        if_val_d      = 1'b0;
        err_d         = err_q;
        hold_cnt_d    = hold_cnt_q;

        case (state_q)
            C_ST_IDLE: begin
                if (start) begin
                    active_core_d = core_mask;
                    word_cnt_d    = ins_len;
                    err_d         = 1'b0;
                    hold_cnt_d    = 1'b0;
                    // Empty programs complete without touching the source.
                    if ((ins_len == '0) || (core_mask == '0)) begin
                        state_d = C_ST_FINISH;
                    end else begin
                        state_d = C_ST_WAIT_RTR;
                    end
                end
            end

            C_ST_WAIT_RTR: begin
                // A pop in the expiring cycle still counts as a clean exit.
                if (w_pop) begin
                    mess_d   = ins_data;
                    if_val_d = 1'b1;
                    state_d  = C_ST_ISSUE;
                end else if (w_expired) begin
                    err_d   = 1'b1;
                    state_d = C_ST_FINISH;
                end
            end

            C_ST_ISSUE: begin
                word_cnt_d = word_cnt_q - 1'b1;
                hold_cnt_d = 1'b0;
                state_d    = C_ST_HOLD;
            end

            C_ST_HOLD: begin
                if (!hold_cnt_q) begin
                    hold_cnt_d = 1'b1;
                end else if (word_cnt_q != '0) begin
                    state_d = C_ST_WAIT_RTR;
                end else begin
                    state_d = C_ST_WAIT_READY;
                end
            end

            C_ST_WAIT_READY: begin
                if (w_all_ready) begin
                    state_d = C_ST_FINISH;
                end else if (w_expired) begin
                    err_d   = 1'b1;
                    state_d = C_ST_FINISH;
                end
            end

            C_ST_FINISH: begin
                state_d = C_ST_IDLE;
            end

            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= C_ST_IDLE;
            active_core_q <= '0;
            word_cnt_q    <= '0;
            mess_q        <= '0;
            if_val_q      <= 1'b0;
            err_q         <= 1'b0;
            hold_cnt_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_core_q <= active_core_d;
            word_cnt_q    <= word_cnt_d;
            mess_q        <= mess_d;
            if_val_q      <= if_val_d;
            err_q         <= err_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    // Pop is combinational; gate it with rst so a reset cycle never pops.
    assign ins_rd       = w_pop && !rst;
    assign mess_from_ts = mess_q;
    assign if_val       = if_val_q;
    assign active_core  = active_core_q;
    assign busy         = (state_q != C_ST_IDLE);
    assign done         = (state_q == C_ST_FINISH);
    assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_core_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_dispatch_ctrl
//  Description : Self-checking bench for core_dispatch_ctrl. Programs are
//                issued from a stimulus thread that pushes the expected
//                words into a scoreboard queue; a monitor pops and compares
//                on every if_val and checks completion on every done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_dispatch_ctrl;

    localparam int NC = 16;
    localparam int MW = 16;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start = 1'b0, start_b = 1'b0;
    logic [NC-1:0] core_mask = '0;
    logic [LW-1:0] ins_len = '0;
    logic [MW-1:0] ins_data = '0;
    logic          ins_valid = 1'b0;
    logic [NC-1:0] rtr_bus = '0, ready_bus = '0;

    logic          ins_rd, if_val, busy, done, err;
    logic [MW-1:0] mess;
    logic [NC-1:0] active_core;
    logic          ins_rd_b, if_val_b, busy_b, done_b, err_b;
    logic [MW-1:0] mess_b;
    logic [NC-1:0] active_core_b;

    core_dispatch_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .core_mask(core_mask), .ins_len(ins_len),
        .ins_data(ins_data), .ins_valid(ins_valid), .ins_rd(ins_rd), .mess_from_ts(mess),
        .if_val(if_val), .active_core(active_core), .rtr_bus(rtr_bus), .ready_bus(ready_bus),
        .busy(busy), .done(done), .err(err)
    );

    core_dispatch_ctrl #(.TIMEOUT_CYC(16)) u_dut_to (
        .clk(clk), .rst(rst), .start(start_b), .core_mask(core_mask), .ins_len(ins_len),
        .ins_data(ins_data), .ins_valid(ins_valid), .ins_rd(ins_rd_b), .mess_from_ts(mess_b),
        .if_val(if_val_b), .active_core(active_core_b), .rtr_bus(rtr_bus), .ready_bus(ready_bus),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic rst_smp = 1'b1;

    logic [MW-1:0] src_q[$];
    logic [MW-1:0] exp_q[$];
    logic [MW-1:0] words_q[$];
    logic          pop_pend = 1'b0;
    logic          rnd_bus = 1'b0, rnd_valid = 1'b0;
    logic [NC-1:0] rtr_set = '0, ready_set = '0;
    logic [NC-1:0] exp_mask = '0;
    logic [MW-1:0] last_mess = '0;
    int last_if = -100;
    int rd_cnt = 0, if_cnt = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0, st_cyc = 0;
    int if_cyc_q[$];
    int rd_cnt_b = 0, if_cnt_b = 0, done_cnt_b = 0, done_cyc_b = 0;
    logic err_done_b = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Instruction source and core status buses.
    always @(posedge clk) begin
        cyc     = cyc + 1;
        rst_smp = rst;
        #1;
        if (pop_pend && (src_q.size() > 0)) void'(src_q.pop_front());
        ins_valid = (src_q.size() > 0) && (!rnd_valid || ($urandom_range(0, 3) != 0));
        ins_data  = (src_q.size() > 0) ? src_q[0] : '0;
        if (rnd_bus) begin
            rtr_bus   = ($urandom_range(0, 1) != 0) ? '1 : NC'($urandom);
            ready_bus = ($urandom_range(0, 1) != 0) ? '1 : NC'($urandom);
        end else begin
            rtr_bus   = rtr_set;
            ready_bus = ready_set;
        end
    end

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        pop_pend = ins_rd;
        if (ins_rd) rd_cnt++;
        if (busy) busy_cnt++;
        if (rst_smp) begin
            last_mess = '0;
            last_if   = -100;
        end else begin
            if (if_val) begin
                if_cnt++;
                if_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ifval_unexpected: got word %0h, none expected (cycle %0d)", mess, cyc);
                end else begin
                    chk("word", mess, exp_q.pop_front());
                end
                chk("word_spacing_ok", ((cyc - last_if) >= 4) ? 1 : 0, 1);
                chk("active_core", active_core, exp_mask);
                last_mess = mess;
                last_if   = cyc;
            end else begin
                chk("mess_hold", mess, last_mess);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_all_issued", exp_q.size(), 0);
                chk("done_err", err, 0);
            end
        end
    end

    // Event counters for the short-timeout instance.
    always @(negedge clk) begin
        if (ins_rd_b) rd_cnt_b++;
        if (if_val_b) if_cnt_b++;
        if (done_b) begin
            done_cnt_b++;
            done_cyc_b = cyc;
            err_done_b = err_b;
        end
    end

    task automatic run_prog(input logic [NC-1:0] m, input int len);
        int n0, guard, i0;
        logic [MW-1:0] w;
        i0 = if_cnt;
        for (int i = 0; i < len; i++) begin
            w = (words_q.size() > 0) ? words_q.pop_front() : MW'($urandom);
            if (m != '0) begin
                src_q.push_back(w);
                exp_q.push_back(w);
            end
        end
        tick();
        n0       = done_cnt;
        exp_mask = m;
        st_cyc   = cyc;
        last_if  = cyc - 2;
        start = 1'b1; core_mask = m; ins_len = LW'(len);
        tick();
        start = 1'b0; core_mask = NC'($urandom); ins_len = LW'($urandom);
        guard = 0;
        while ((done_cnt == n0) && (guard < len * 64 + 64)) begin
            tick();
            guard++;
        end
        if (done_cnt == n0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done after %0d cycles", guard);
        end
        chk("idle_after_done", busy, 0);
        chk("words_issued", if_cnt - i0, (m != '0) ? len : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "global timeout");
    end

    initial begin
        int n0, rd0, guard, i0;
        logic [NC-1:0] m;
        int l;

        // Reset state
        rst = 1'b1;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_if_val", if_val, 0);
        chk("rst_ins_rd", ins_rd, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_active_core", active_core, 0);
        chk("rst_mess", mess, 0);
        rst = 1'b0;
        tick(2);

        // Nominal program
        rtr_set = 16'h000F; ready_set = 16'h000F;
        tick();
        words_q = '{16'h00A1, 16'h00A2, 16'h00A3};
        if_cyc_q.delete();
        run_prog(16'h000F, 3);
        chk("nom_if_count", if_cyc_q.size(), 3);
        if (if_cyc_q.size() == 3) begin
            chk("nom_first_if", if_cyc_q[0], st_cyc + 2);
            chk("nom_second_if", if_cyc_q[1], st_cyc + 6);
            chk("nom_third_if", if_cyc_q[2], st_cyc + 10);
        end
        chk("nom_done_cycle", done_cyc, st_cyc + 14);

        // Zero length
        busy_cnt = 0;
        rd0 = rd_cnt;
        run_prog(16'hFFFF, 0);
        chk("zero_done_cycle", done_cyc, st_cyc + 1);
        chk("zero_busy_cycles", busy_cnt, 1);
        chk("zero_no_pop", rd_cnt - rd0, 0);

        // Zero mask
        rd0 = rd_cnt;
        run_prog(16'h0000, 5);
        chk("zmask_no_pop", rd_cnt - rd0, 0);

        // Partial rtr
        rtr_set = 16'h0001; ready_set = 16'h0005;
        src_q.push_back(16'h00B7);
        exp_q.push_back(16'h00B7);
        tick();
        rd0 = rd_cnt; n0 = done_cnt; exp_mask = 16'h0005; last_if = cyc - 2;
        start = 1'b1; core_mask = 16'h0005; ins_len = 8'd1;
        tick();
        start = 1'b0;
        tick(9);
        rtr_set = 16'hFFFB;
        tick(10);
        chk("partial_no_pop", rd_cnt - rd0, 0);
        rtr_set = 16'h0005;
        guard = 0;
        while ((done_cnt == n0) && (guard < 100)) begin
            tick();
            guard++;
        end
        chk("partial_done_seen", done_cnt - n0, 1);
        chk("partial_one_pop", rd_cnt - rd0, 1);

        // Timeout on the short-timeout instance
        rtr_set = 16'h0000; ready_set = 16'h0000;
        tick(2);
        n0 = done_cnt_b; st_cyc = cyc;
        start_b = 1'b1; core_mask = 16'h0001; ins_len = 8'd2;
        tick();
        start_b = 1'b0;
        guard = 0;
        while ((done_cnt_b == n0) && (guard < 100)) begin
            tick();
            guard++;
        end
        chk("to_done_seen", done_cnt_b - n0, 1);
        chk("to_done_cycle", done_cyc_b, st_cyc + 17);
        chk("to_err_at_done", err_done_b, 1);
        chk("to_no_ifval", if_cnt_b, 0);
        chk("to_no_pop", rd_cnt_b, 0);
        tick(3);
        chk("to_err_sticky", err_b, 1);
        chk("to_idle", busy_b, 0);
        start_b = 1'b1; core_mask = 16'h0001; ins_len = 8'd0;
        tick();
        start_b = 1'b0;
        chk("to_err_cleared", err_b, 0);
        tick(2);

        // Start while busy, then reset in HOLD
        rtr_set = '1; ready_set = '1;
        for (int i = 0; i < 3; i++) begin
            src_q.push_back(MW'($urandom));
            exp_q.push_back(src_q[i]);
        end
        tick();
        i0 = if_cnt; n0 = done_cnt; exp_mask = 16'h000F; st_cyc = cyc; last_if = cyc - 2;
        start = 1'b1; core_mask = 16'h000F; ins_len = 8'd3;
        tick();
        start = 1'b0;
        tick(2);
        start = 1'b1; core_mask = 16'h00F0; ins_len = 8'd5;
        tick();
        start = 1'b0;
        chk("busy_start_mask", active_core, 16'h000F);
        chk("busy_start_still_busy", busy, 1);
        tick(3);
        chk("pre_rst_words", if_cnt - i0, 2);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_if_val", if_val, 0);
        chk("mid_rst_ins_rd", ins_rd, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_active_core", active_core, 0);
        chk("mid_rst_mess", mess, 0);
        rst = 1'b0;
        exp_q.delete();
        src_q.delete();
        tick(30);
        chk("rst_no_done", done_cnt - n0, 0);
        chk("rst_stays_idle", busy, 0);
        chk("rst_no_resume", if_cnt - i0, 2);

        // Maximum length
        run_prog(16'h8001, 255);

        // Randomized programs
        rnd_bus = 1'b1; rnd_valid = 1'b1;
        for (int k = 0; k < 25; k++) begin
            m = ($urandom_range(0, 7) == 0) ? '0 : NC'($urandom);
            l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
            run_prog(m, l);
        end
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
